// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: line-rate defaults, frame size, FSM encodings.
// Parity framing is selected with `UART_RX_PARITY_EN (see uart_rx.sv).
package uart_rx_pkg;
    localparam int CLK_FREQ         = 50_000_000;
    localparam int BAUD_RATE        = 9600;
    localparam int DEF_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int SIM_CLKS_PER_BIT = 56;
    localparam int BIT_END          = 8;
    localparam int BAUD_W           = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Byte-delivery side of the UART receiver: data, strobes and busy flag.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (output rx_data, rx_valid, rx_frame_err, rx_busy);
    modport slave  (input  rx_data, rx_valid, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_baud_gen.sv
// Bit-period counter: runs while enabled, flags mid-bit and end-of-bit positions.
module uart_rx_baud_gen
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic mid_tick,
    output logic end_tick
);
    logic [BAUD_W-1:0] cnt;

    assign mid_tick = en && (cnt == BAUD_W'(CLKS_PER_BIT / 2 - 1));
    assign end_tick = en && (cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || !en)
            cnt <= '0;
        else if (end_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; define UART_RX_PARITY_EN for 8E1 framing.
// Start bit is qualified at mid-bit, then every sample lands on a bit centre.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    uart_rx_if.master bus
);
    rx_state_e  state;
    logic       rx_meta, rx_s;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       mid_tick, end_tick;
    logic       stop_ok;

    // Counter restarts at the start-bit centre so later samples sit mid-bit.
    uart_rx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (state != ST_IDLE),
        .clr      ((state == ST_START) && mid_tick),
        .mid_tick (mid_tick),
        .end_tick (end_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign stop_ok = rx_s && !par_err;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            rx_meta          <= 1'b1;
            rx_s             <= 1'b1;
            shift_reg        <= '0;
            bit_cnt          <= '0;
            bus.rx_data      <= '0;
            bus.rx_valid     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err          <= 1'b0;
`endif
        end else begin
            rx_meta          <= rx;
            rx_s             <= rx_meta;
            bus.rx_valid     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: if (!rx_s) begin
                    state       <= ST_START;
                    bus.rx_busy <= 1'b1;
                    bit_cnt     <= '0;
                end
                ST_START: if (mid_tick) begin
                    if (rx_s) begin
                        state       <= ST_IDLE;
                        bus.rx_busy <= 1'b0;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (end_tick) begin
                    shift_reg <= {rx_s, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'(BIT_END - 1))
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (end_tick) begin
                    par_err <= (rx_s != ^shift_reg);
                    state   <= ST_STOP;
                end
`endif
                ST_STOP: if (end_tick) begin
                    state       <= ST_IDLE;
                    bus.rx_busy <= 1'b0;
                    if (stop_ok) begin
                        bus.rx_data  <= shift_reg;
                        bus.rx_valid <= 1'b1;
                    end else begin
                        bus.rx_frame_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 56 clocks/bit: frame table plus glitch, reset and parity sequences.
module tb_uart_rx;
    localparam int CPB = 56;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    vec_t       vecs[7];
    logic       prev_valid = 1'b0;
    logic       prev_err   = 1'b0;

    uart_rx_if dut_if();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (dut_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    task automatic push_exp(input logic is_err, input logic [7:0] d);
        exp_t e;
        if (!is_err) last_good = d;
        e.is_err = is_err;
        e.data   = is_err ? last_good : d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.rx_valid || dut_if.rx_frame_err) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_strobe: valid=%b err=%b data=0x%02h, expected no strobe",
                             dut_if.rx_valid, dut_if.rx_frame_err, dut_if.rx_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (dut_if.rx_frame_err === e.is_err && dut_if.rx_valid === !e.is_err &&
                        dut_if.rx_data === e.data)
                        pass_cnt++;
                    else
                        $display("FAIL frame: valid=%b err=%b data=0x%02h, expected valid=%b err=%b data=0x%02h",
                                 dut_if.rx_valid, dut_if.rx_frame_err, dut_if.rx_data,
                                 !e.is_err, e.is_err, e.data);
                end
            end
            if ((dut_if.rx_valid && prev_valid) || (dut_if.rx_frame_err && prev_err)) begin
                total_cnt++;
                $display("FAIL strobe_width: strobe high for 2+ cycles, expected 1");
            end
        end
        prev_valid = dut_if.rx_valid;
        prev_err   = dut_if.rx_frame_err;
    end

    initial begin
        int busy_cycles;

        vecs[0] = '{8'hA5, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0};
        vecs[3] = '{8'h55, 1'b1, 2};
        vecs[4] = '{8'h3C, 1'b0, 2};
        vecs[5] = '{8'hC3, 1'b1, 1};
        vecs[6] = '{8'h81, 1'b1, 1};

        repeat (3) @(negedge clk);
        chk("reset_data",  dut_if.rx_data,      0);
        chk("reset_valid", dut_if.rx_valid,     0);
        chk("reset_err",   dut_if.rx_frame_err, 0);
        chk("reset_busy",  dut_if.rx_busy,      0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Frame table: first four back-to-back, bad stop bit on 0x3C.
        for (int v = 0; v < 7; v++) begin
            push_exp(!vecs[v].stop, vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop);
            rx = 1'b1;
            repeat (vecs[v].gap * CPB) @(negedge clk);
        end
        drain("drain_table");

        // 10-clock low glitch: busy for half a bit, then back to idle silently.
        busy_cycles = 0;
        rx = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (i == 10) rx = 1'b1;
            @(negedge clk);
            if (dut_if.rx_busy) busy_cycles++;
        end
        chk("glitch_busy_cycles", busy_cycles, CPB / 2);
        chk("glitch_idle", dut_if.rx_busy, 0);

        // Reset during bit 4 of 0x81.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(logic'(8'h81 >> i));
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data",  dut_if.rx_data,      0);
        chk("midrst_valid", dut_if.rx_valid,     0);
        chk("midrst_err",   dut_if.rx_frame_err, 0);
        chk("midrst_busy",  dut_if.rx_busy,      0);
        rst = 1'b0;
        last_good = 8'h00;
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        push_exp(1'b0, 8'h81);
        send_frame(8'h81, 1'b1);
        drain("drain_after_reset");

`ifdef UART_RX_PARITY_EN
        push_exp(1'b0, 8'h07);
        send_frame_par(8'h07, 1'b1);
        push_exp(1'b1, 8'h07);
        send_frame_par(8'h07, 1'b0);
        drain("drain_parity");
`endif

        repeat (2 * CPB) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
